// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU/compare codes, opcodes,
// FSM state encoding and the instruction decode helper.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned IMM_W  = 6;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_BNE  = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // Decoded view of one instruction word.
  typedef struct packed {
    logic              legal;
    logic              is_bne;
    logic              is_imm;
    logic              wr;      // instruction writes a destination register
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [IMM_W-1:0]  imm;
  } dec_t;

  function automatic dec_t decode(input logic [DATA_W-1:0] ins);
    dec_t d;
    d        = '0;
    d.rs     = ins[11:9];
    d.rt     = ins[8:6];
    d.imm    = ins[5:0];
    d.dest   = ins[5:3];
    d.ctrl   = ins[2:0];
    case (ins[15:12])
      OP_R: begin
        d.wr = 1'b1;
        case (ins[2:0])
          ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: d.legal = 1'b1;
          default:                                    d.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.legal  = 1'b1;
        d.is_imm = 1'b1;
        d.wr     = 1'b1;
        d.dest   = ins[8:6];
        d.ctrl   = ALU_ADD;
      end
      OP_BNE: begin
        d.legal  = 1'b1;
        d.is_bne = 1'b1;
        d.ctrl   = ALU_SUB;
      end
      default: d.legal = 1'b0;
    endcase
    if (!d.legal) d.wr = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// 8x16 register file: one write port, three combinational read ports.
// r0 always reads zero and ignores writes.
// Ports: clk, rst_n (sync, active-low), we/waddr/wdata write port,
//        raddr_a/b/d -> rdata_a/b/d read ports (rs, rt, debug).
module issue_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] raddr_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Storage; r0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];
  assign rdata_d = (raddr_d == '0) ? '0 : mem_q[raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of a combinational 16-bit ALU. Accepts one
// instruction per handshake, decodes it, drives ALU operands/control,
// samples the ALU result and retires with register writeback and pc update.
// Ports: clk, rst_n (sync, active-low); instr/instr_valid/instr_ready
//        handshake; alu_a/alu_b/alu_control/alu_c_in to the ALU;
//        alu_result/alu_c_out/alu_overflow/alu_comp/alu_slt from the ALU;
//        pc, done, illegal, flags status; dbg_addr -> dbg_data debug read.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  output logic [2:0]        alu_control,
  output logic              alu_c_in,
  input  logic [15:0]       alu_result,
  input  logic              alu_c_out,
  input  logic              alu_overflow,
  input  logic [2:0]        alu_comp,
  input  logic              alu_slt,
  output logic [PC_W-1:0]   pc,
  output logic              done,
  output logic              illegal,
  output logic [2:0]        flags,
  input  logic [2:0]        dbg_addr,
  output logic [15:0]       dbg_data
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                alu_c_in_q, alu_c_in_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic [2:0]          flags_q, flags_d;

  dec_t                dec;
  logic [DATA_W-1:0]   rs_data, rt_data;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;
  logic                bne_taken;
  logic [PC_W-1:0]     pc_inc, pc_br;

  assign dec       = decode(ir_q);
  assign bne_taken = (alu_comp != CMP_EQ);
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_br     = pc_inc + PC_W'($signed(dec.imm));
  // SLT retires only the set-on-less-than bit, zero-extended.
  assign rf_wdata  = (alu_ctrl_q == ALU_SLT) ? {15'b0, alu_slt} : alu_result;

  issue_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (dec.dest),
    .wdata   (rf_wdata),
    .raddr_a (dec.rs),
    .raddr_b (dec.rt),
    .raddr_d (dbg_addr),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .rdata_d (dbg_data)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= ALU_AND;
      alu_c_in_q <= 1'b0;
      pc_q       <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_c_in_q <= alu_c_in_d;
      pc_q       <= pc_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      flags_q    <= flags_d;
    end
  end

  // Next state; done/flags/pc/writeback all commit on the edge into WB so the
  // done pulse is visible for the whole WB cycle.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_c_in_d = alu_c_in_q;
    pc_d       = pc_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    flags_d    = flags_q;
    rf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          alu_a_d    = rs_data;
          alu_b_d    = dec.is_imm ? DATA_W'($signed(dec.imm)) : rt_data;
          alu_ctrl_d = dec.ctrl;
          alu_c_in_d = (dec.ctrl == ALU_SUB);
          state_d    = ST_EXEC;
        end else begin
          // ALU outputs keep their previous values for illegal words.
          done_d    = 1'b1;
          illegal_d = 1'b1;
          flags_d   = '0;
          pc_d      = pc_inc;
          state_d   = ST_WB;
        end
      end
      ST_EXEC: begin
        done_d  = 1'b1;
        state_d = ST_WB;
        if (dec.is_bne) begin
          flags_d = {2'b00, bne_taken};
          pc_d    = bne_taken ? pc_br : pc_inc;
        end else begin
          flags_d = {alu_c_out, alu_overflow, 1'b0};
          rf_we   = dec.wr;
          pc_d    = pc_inc;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign alu_c_in    = alu_c_in_q;
  assign pc          = pc_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign flags       = flags_q;

endmodule
